// File: rtl/ola_pkg.sv
// Shared definitions for the logic-analyser capture path: capture state encoding.
package ola_pkg;

  typedef enum logic [2:0] {
    OLA_CAP_IDLE = 3'd0,
    OLA_CAP_PRE  = 3'd1,
    OLA_CAP_WAIT = 3'd2,
    OLA_CAP_POST = 3'd3,
    OLA_CAP_DONE = 3'd4
  } ola_cap_state_t;

endpackage

// File: rtl/ola_capture_pointer.sv
// Wrapping sample-memory write pointer with trigger/start address latch.
// start_addr is the trigger address minus the pre-trigger depth, modulo the ring size.
module ola_capture_pointer #(
  parameter int addr_width = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  latch_trigger,
  input  logic [addr_width-1:0] pre_offset,
  output logic [addr_width-1:0] wr_ptr,
  output logic [addr_width-1:0] trigger_addr,
  output logic [addr_width-1:0] start_addr
);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      trigger_addr <= '0;
      start_addr   <= '0;
    end else begin
      if (advance) wr_ptr <= wr_ptr + 1'b1;
      if (latch_trigger) begin
        trigger_addr <= wr_ptr;
        start_addr   <= wr_ptr - pre_offset;
      end
    end
  end

endmodule

// File: rtl/ola_capture_control.sv
// Capture sequencer: pre-trigger fill, trigger wait, post-trigger record, stop.
// Optional build macro OLA_CAPTURE_FORCE_EN adds the cfg_force software trigger.
//
// state | meaning
// IDLE  | no capture, no writes
// PRE   | filling the guaranteed pre-trigger history
// WAIT  | ring wraps freely, waiting for a trigger sample
// POST  | recording samples after the trigger
// DONE  | capture complete, addresses held for readout
module ola_capture_control
  import ola_pkg::*;
#(
  parameter int sample_width = 8,
  parameter int addr_width   = 10,
  parameter int count_width  = addr_width + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_arm,
  input  logic                    cfg_abort,
  input  logic [count_width-1:0]  cfg_pre_count,
  input  logic [count_width-1:0]  cfg_post_count,
  input  logic                    in_valid,
  input  logic [sample_width-1:0] in_sample,
  input  logic                    in_trigger,
`ifdef OLA_CAPTURE_FORCE_EN
  input  logic                    cfg_force,
`endif
  output logic                    mem_write,
  output logic [addr_width-1:0]   mem_addr,
  output logic [sample_width-1:0] mem_data,
  output logic [2:0]              out_state,
  output logic                    out_busy,
  output logic                    out_done,
  output logic [addr_width-1:0]   out_trigger_addr,
  output logic [addr_width-1:0]   out_start_addr
);

  localparam logic [count_width-1:0] depth_m1 = count_width'((1 << addr_width) - 1);

  ola_cap_state_t state_q, state_d;
  logic [count_width-1:0] pre_clamp, post_room, post_clamp;
  logic [count_width-1:0] pre_lat, post_lat, pre_cnt, post_cnt;
  logic [addr_width-1:0]  wr_ptr;
  logic                   in_capture, take, hit, arm_go, force_now;

  // Post depth is limited by whatever ring space the pre history leaves.
  always_comb begin
    pre_clamp  = (cfg_pre_count > depth_m1) ? depth_m1 : cfg_pre_count;
    post_room  = depth_m1 - pre_clamp;
    post_clamp = (cfg_post_count > post_room) ? post_room : cfg_post_count;
  end

`ifdef OLA_CAPTURE_FORCE_EN
  logic force_pend_q;
  assign force_now = force_pend_q | cfg_force;

  always_ff @(posedge clock) begin
    if (reset) begin
      force_pend_q <= 1'b0;
    end else if (!(state_d inside {OLA_CAP_PRE, OLA_CAP_WAIT})) begin
      force_pend_q <= 1'b0;
    end else if (cfg_force && (state_q inside {OLA_CAP_PRE, OLA_CAP_WAIT})) begin
      force_pend_q <= 1'b1;
    end
  end
`else
  assign force_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    arm_go     = 1'b0;
    in_capture = state_q inside {OLA_CAP_PRE, OLA_CAP_WAIT, OLA_CAP_POST};
    take       = in_capture && in_valid && !cfg_abort;
    hit        = take && (state_q == OLA_CAP_WAIT) && (in_trigger || force_now);
    if (cfg_abort) begin
      state_d = OLA_CAP_IDLE;
    end else begin
      case (state_q)
        OLA_CAP_IDLE, OLA_CAP_DONE: begin
          if (cfg_arm) begin
            arm_go  = 1'b1;
            state_d = (pre_clamp == '0) ? OLA_CAP_WAIT : OLA_CAP_PRE;
          end
        end
        OLA_CAP_PRE:  if (take && (pre_cnt + 1'b1 == pre_lat)) state_d = OLA_CAP_WAIT;
        OLA_CAP_WAIT: if (hit) state_d = (post_lat == '0) ? OLA_CAP_DONE : OLA_CAP_POST;
        OLA_CAP_POST: if (take && (post_cnt == count_width'(1))) state_d = OLA_CAP_DONE;
        default:      state_d = OLA_CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= OLA_CAP_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      pre_lat   <= '0;
      post_lat  <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
    end else begin
      mem_write <= take;
      if (take) begin
        mem_addr <= wr_ptr;
        mem_data <= in_sample;
      end
      if (arm_go) begin
        pre_lat  <= pre_clamp;
        post_lat <= post_clamp;
        pre_cnt  <= '0;
      end else if (take && (state_q == OLA_CAP_PRE)) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (hit) post_cnt <= post_lat;
      else if (take && (state_q == OLA_CAP_POST)) post_cnt <= post_cnt - 1'b1;
    end
  end

  ola_capture_pointer #(.addr_width(addr_width)) u_pointer (
    .clock         (clock),
    .reset         (reset),
    .advance       (take),
    .latch_trigger (hit),
    .pre_offset    (pre_lat[addr_width-1:0]),
    .wr_ptr        (wr_ptr),
    .trigger_addr  (out_trigger_addr),
    .start_addr    (out_start_addr)
  );

  assign out_state = state_q;
  assign out_busy  = in_capture;
  assign out_done  = (state_q == OLA_CAP_DONE);

endmodule

// File: doc/ola_capture_control.md
Name: ola_capture_control

Overview:
- Sequences one logic-analyser capture around the trigger engine.
- Takes the analysed sample stream and the trigger strobe, and writes samples into an external circular sample memory.
- Guarantees a programmed number of pre-trigger samples, records a programmed number of post-trigger samples, then stops.
- Reports the trigger address and the start address so readout can unroll the ring.

Parameters:
- sample_width, 8, width of one sample word
- addr_width, 10, sample memory address width; depth = 2**addr_width
- count_width, addr_width+1, width of the pre/post count configuration fields

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_arm  in  1  start-capture strobe
- cfg_abort  in  1  cancel-capture strobe
- cfg_pre_count  in  count_width  pre-trigger samples required
- cfg_post_count  in  count_width  samples stored after the trigger sample
- in_valid  in  1  sample strobe
- in_sample  in  sample_width  sample data
- in_trigger  in  1  trigger strobe, qualified by in_valid
- mem_write  out  1  memory write enable
- mem_addr  out  addr_width  memory write address
- mem_data  out  sample_width  memory write data
- out_state  out  3  current state encoding
- out_busy  out  1  high in PRE, WAIT and POST
- out_done  out  1  high in DONE
- out_trigger_addr  out  addr_width  address of the trigger sample
- out_start_addr  out  addr_width  address of the oldest valid sample

Behaviour:
- Reset (synchronous, active-high) drives:
  - state = IDLE
  - mem_write = 0, mem_addr = 0, mem_data = 0
  - out_trigger_addr = 0, out_start_addr = 0
  - internal pre/post counters = 0
- States and encodings: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- Configuration latching and clamping:
  - cfg_pre_count and cfg_post_count are latched on the accepted arm.
  - pre is clamped to depth-1.
  - post is clamped to depth-1-pre.
- Write path, registered with 1-cycle latency:
  - In PRE, WAIT and POST, each in_valid produces mem_write=1 on the next cycle, with mem_data=in_sample and mem_addr = write pointer.
  - The write pointer then increments, wrapping modulo depth.
  - mem_write is 0 in IDLE and DONE, and whenever in_valid=0.
- IDLE:
  - cfg_arm -> PRE.
  - The write pointer is kept, not cleared; the pre-sample counter is cleared.
  - If latched pre=0, cfg_arm goes directly to WAIT.
- PRE:
  - Counts stored samples; in_trigger is ignored.
  - When the count reaches pre (on the valid sample that completes it) -> WAIT.
- WAIT:
  - Ring wraps freely.
  - A valid sample with in_trigger=1 is stored, and its address is latched into out_trigger_addr.
  - out_start_addr = trigger address - pre (mod depth).
  - If post=0 -> DONE; otherwise -> POST with the post counter = post.
- POST:
  - Each valid sample decrements the post counter.
  - The sample that brings it to 0 is stored, then -> DONE.
  - in_trigger is ignored.
- DONE:
  - No writes.
  - Addresses are held stable until the next arm.
  - cfg_arm -> PRE (or WAIT if pre=0), starting a new capture.
- Abort and strobe priority:
  - cfg_abort in any state -> IDLE next cycle, and it takes priority over cfg_arm and in_trigger in the same cycle.
  - A sample arriving in the abort cycle is not written.
  - cfg_arm in PRE, WAIT or POST is ignored.
- Timing:
  - The trigger sample's write occurs in the cycle after it is presented, like every other sample.
  - The state transition and the address latch update in that same edge.
- Reset mid-capture: abandons the capture entirely; memory contents are undefined to the reader.

Optional Feature:
- Macro: OLA_CAPTURE_FORCE_EN.
- When defined:
  - Adds input port cfg_force (1 bit).
  - In WAIT, cfg_force=1 makes the next valid sample be treated as the trigger sample, exactly as if in_trigger were 1.
  - In PRE, cfg_force is remembered and applied at the first valid sample in WAIT.
  - The remembered force is cleared by abort, reset or entering DONE.
- When undefined: the port is absent and only in_trigger triggers.

Decomposition:
- Shared package ola_pkg:
  - state encoding constants (OLA_CAP_IDLE..OLA_CAP_DONE)
  - state typedef, 3 bits
- Natural sub-module ola_capture_pointer:
  - wrapping write pointer plus trigger/start address latch and modulo subtraction
  - reused later by the readout block
- Counters and the FSM stay in the top module.

Test Plan (addr_width=4, depth 16):
- Basic capture: pre=4, post=3, arm, trigger on the 9th valid sample.
  - Writes at addresses 0..11.
  - out_trigger_addr=8, out_start_addr=4.
  - DONE after the write to address 11; exactly 12 mem_write pulses.
- Early trigger ignored: pre=6, in_trigger on valid samples 2 and 4, then on sample 10.
  - Trigger taken at sample 10; out_trigger_addr=9.
- Wrap-around: pre=2, post=2, trigger after 20 valid samples.
  - mem_addr wraps 15->0; out_trigger_addr=3, out_start_addr=1.
- Clamp and zero: pre=20, post=20.
  - Clamped to pre=15, post=0; DONE immediately after the trigger write.
- Separately pre=0, post=0: cfg_arm -> WAIT, and the first trigger sample -> DONE.
- Abort and priority: in POST assert cfg_abort together with in_valid and cfg_arm.
  - No write that cycle; state=IDLE next cycle; out_busy=0.
- Synchronous reset during WAIT: reset held 1 cycle.
  - The next cycle shows state=0, mem_write=0, mem_addr=0, and all outputs at reset values.
- With OLA_CAPTURE_FORCE_EN: cfg_force pulsed in PRE with no in_trigger.
  - The first valid sample in WAIT becomes the trigger sample and is captured.
